// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants, state encodings and helpers
// for the 8-way round-robin mux scheduler.
package mux8_rr_sched_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_GRANT = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;

   function automatic logic [N_REQ-1:0] onehot8(
      input logic [SEL_W-1:0] idx
   );
      onehot8 = N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux8_rr_sched_if.sv
// Requester-side bundle: requests in, grant and
// mux control out.
interface mux8_rr_sched_if;
   import mux8_rr_sched_pkg::*;

   logic [N_REQ-1:0] REQ;
   logic [N_REQ-1:0] GNT;
   logic             S0;
   logic             S1;
   logic             S2;
   logic             E;
   logic             LAST;
   logic             BUSY;

   modport master (
      output REQ,
      input  GNT, S0, S1, S2, E, LAST, BUSY
   );

   modport slave (
      input  REQ,
      output GNT, S0, S1, S2, E, LAST, BUSY
   );

endinterface

// File: rtl/mux8_rr_sched_rr_pick8.sv
// Rotating priority encoder: first set request
// at or after ptr, wrapping modulo 8.
module rr_pick8
   import mux8_rr_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [SEL_W-1:0]   off;

   assign dbl = {req, req} >> ptr;
   assign rot = dbl[N_REQ-1:0];
   assign any = |req;

   // scan downward so the lowest offset wins
   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
   end

   assign idx = ptr + off;

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler for a shared 8:1 enabled
// mux with bounded bursts and a dead cycle between owners.
module mux8_rr_sched
   import mux8_rr_sched_pkg::*;
#(
   parameter int CNT_W     = 4,
   parameter int MAX_BURST = 8
) (
   input logic             C,
   input logic             R,
   mux8_rr_sched_if.slave  bus
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             e_q, e_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;

   rr_pick8 u_pick (
      .req (bus.REQ),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      e_d     = e_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE, ST_GAP: begin
            if (pick_any) begin
               state_d = ST_GRANT;
               gnt_d   = onehot8(pick_idx);
               sel_d   = pick_idx;
               e_d     = 1'b1;
               cnt_d   = CNT_W'(1);
               last_d  = (MAX_BURST == 1);
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               e_d     = 1'b0;
               last_d  = 1'b0;
            end
         end
         ST_GRANT: begin
            // owner gone or burst exhausted: one release path
            if (!bus.REQ[sel_q] || cnt_q == MAX_C) begin
               state_d = ST_GAP;
               gnt_d   = '0;
               e_d     = 1'b0;
               last_d  = 1'b0;
               ptr_d   = sel_q + SEL_W'(1);
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               last_d = (cnt_q + CNT_W'(1)) == MAX_C;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            e_d     = 1'b0;
            last_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge C) begin
      if (R) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         e_q     <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         e_q     <= e_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.GNT  = gnt_q;
   assign bus.S0   = sel_q[0];
   assign bus.S1   = sel_q[1];
   assign bus.S2   = sel_q[2];
   assign bus.E    = e_q;
   assign bus.LAST = last_q;
   assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: two instances (burst 8 and
// burst 1) against an owner/beat reference model.
module tb_mux8_rr_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mux8_rr_sched_if ia ();
   mux8_rr_sched_if ib ();

   mux8_rr_sched #(.CNT_W(4), .MAX_BURST(8)) dut_a (
      .C   (clk),
      .R   (rst),
      .bus (ia.slave)
   );

   mux8_rr_sched #(.CNT_W(4), .MAX_BURST(1)) dut_b (
      .C   (clk),
      .R   (rst),
      .bus (ib.slave)
   );

   int checks   = 0;
   int failures = 0;

   // reference model, one slot per instance
   int m_mb [2] = '{8, 1};
   int m_own [2];
   int m_beats [2];
   int m_ptr [2];
   int m_sel [2];
   bit m_last [2];
   bit m_gap [2];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(int u, logic [7:0] req, bit r);
      bit found;
      int j;
      if (r) begin
         m_own[u]   = -1;
         m_beats[u] = 0;
         m_ptr[u]   = 0;
         m_sel[u]   = 0;
         m_last[u]  = 0;
         m_gap[u]   = 0;
      end else if (m_own[u] >= 0) begin
         if (!req[m_own[u]] || m_beats[u] == m_mb[u]) begin
            m_ptr[u]  = (m_own[u] + 1) % 8;
            m_own[u]  = -1;
            m_gap[u]  = 1;
            m_last[u] = 0;
         end else begin
            m_beats[u] = m_beats[u] + 1;
            m_last[u]  = (m_beats[u] == m_mb[u]);
         end
      end else begin
         found = 0;
         m_gap[u] = 0;
         m_last[u] = 0;
         for (int k = 0; k < 8; k++) begin
            j = (m_ptr[u] + k) % 8;
            if (!found && req[j]) begin
               found      = 1;
               m_own[u]   = j;
               m_sel[u]   = j;
               m_beats[u] = 1;
               m_last[u]  = (m_mb[u] == 1);
            end
         end
      end
   endtask

   task automatic cmp_unit(int u, logic [7:0] g, logic [2:0] s,
                           logic e, logic l, logic b,
                           logic [1:0] st, logic [2:0] p);
      logic [7:0] eg;
      string pre;
      pre = $sformatf("u%0d", u);
      eg = (m_own[u] >= 0) ? (8'h01 << m_own[u]) : 8'h00;
      chk({pre, " gnt"}, 32'(g), 32'(eg));
      chk({pre, " sel"}, 32'(s), 32'(m_sel[u]));
      chk({pre, " e"}, 32'(e), 32'(m_own[u] >= 0));
      chk({pre, " last"}, 32'(l), 32'(m_last[u]));
      chk({pre, " busy"}, 32'(b), 32'((m_own[u] >= 0) || m_gap[u]));
      chk({pre, " ptr"}, 32'(p), 32'(m_ptr[u]));
      chk({pre, " state_legal"}, 32'(st != 2'b11), 32'd1);
   endtask

   task automatic cyc(logic [7:0] qa, logic [7:0] qb, bit r);
      ia.REQ = qa;
      ib.REQ = qb;
      rst    = r;
      @(posedge clk);
      model_step(0, qa, r);
      model_step(1, qb, r);
      #1;
      cmp_unit(0, ia.GNT, {ia.S2, ia.S1, ia.S0}, ia.E, ia.LAST,
               ia.BUSY, dut_a.state_q, dut_a.ptr_q);
      cmp_unit(1, ib.GNT, {ib.S2, ib.S1, ib.S0}, ib.E, ib.LAST,
               ib.BUSY, dut_b.state_q, dut_b.ptr_q);
   endtask

   initial begin
      logic [7:0] ra, rb;
      ia.REQ = 8'h00;
      ib.REQ = 8'h00;

      // reset
      cyc(8'h04, 8'h03, 1);
      cyc(8'h04, 8'h03, 1);
      chk("rst gnt", 32'(ia.GNT), 32'h0);
      chk("rst busy", 32'(ia.BUSY), 32'h0);

      // single requester 2; unit b alternates 0/1
      cyc(8'h04, 8'h03, 0);
      chk("t1 gnt", 32'(ia.GNT), 32'h04);
      chk("t1 sel", 32'({ia.S2, ia.S1, ia.S0}), 32'd2);
      chk("t1b gnt", 32'(ib.GNT), 32'h01);
      chk("t1b last", 32'(ib.LAST), 32'h1);
      for (int i = 0; i < 7; i++) cyc(8'h04, 8'h03, 0);
      chk("t1 last8", 32'(ia.LAST), 32'h1);
      cyc(8'h04, 8'h03, 0);
      chk("t1 gap e", 32'(ia.E), 32'h0);
      cyc(8'h04, 8'h03, 0);
      chk("t1 regrant", 32'(ia.GNT), 32'h04);

      // all requesting
      for (int i = 0; i < 80; i++) cyc(8'hFF, 8'h03, 0);

      // owner 3 drops early, then 7 beats 0
      cyc(8'h00, 8'h00, 1);
      cyc(8'h08, 8'h03, 0);
      chk("t3 gnt3", 32'(ia.GNT), 32'h08);
      cyc(8'h89, 8'h03, 0);
      cyc(8'h81, 8'h03, 0);
      chk("t3 gap", 32'(ia.E), 32'h0);
      cyc(8'h81, 8'h03, 0);
      chk("t3 gnt7", 32'(ia.GNT), 32'h80);

      // reset during beat 5 to source 6
      cyc(8'h00, 8'h00, 1);
      for (int i = 0; i < 5; i++) cyc(8'h40, 8'h03, 0);
      chk("t4 beat5", 32'(ia.GNT), 32'h40);
      cyc(8'h40, 8'h03, 1);
      chk("t4 rst gnt", 32'(ia.GNT), 32'h0);
      chk("t4 rst ptr", 32'(dut_a.ptr_q), 32'h0);
      cyc(8'h41, 8'h03, 0);
      chk("t4 gnt0", 32'(ia.GNT), 32'h01);

      // randomized traffic with sticky requests
      ra = 8'h00;
      rb = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) ra = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rb = 8'($urandom);
         cyc(ra, rb, $urandom_range(0, 63) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
